// File: rtl/dds_uart_pkg.sv
// Shared constants and helpers for the DDS control UART link: frame
// header/trailer bytes, frame-FSM encoding and the baud divider.
package dds_uart_pkg;

  localparam logic [7:0] HEAD1_DEF = 8'hAA;
  localparam logic [7:0] HEAD2_DEF = 8'h55;
  localparam logic [7:0] END_DEF   = 8'hCE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  // Cycles per bit, truncating.
  function automatic int baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_frame_encode_if.sv
// Request handshake for the frame encoder: address byte, payload, valid/ready.
interface uart_frame_encode_if #(
  parameter int PAYLOAD_BYTES = 7
);
  logic [7:0]                 req_addr;
  logic [8*PAYLOAD_BYTES-1:0] req_data;
  logic                       req_valid;
  logic                       req_ready;

  modport master (output req_addr, req_data, req_valid, input req_ready);
  modport slave  (input req_addr, req_data, req_valid, output req_ready);
endinterface

// File: rtl/uart_frame_encode_byte_ser.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held
// BAUD_DIV cycles. A load on the byte_done cycle chains bytes with no gap.
module uart_byte_ser #(
  parameter int BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       uart_txd,
  output logic       byte_done
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic          active;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;

  // bit_idx: 0 = start, 1..8 = data, 9 = stop
  assign byte_done = active && (cnt == '0) && (bit_idx == 4'd9);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      cnt      <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
    end else if (load) begin
      active   <= 1'b1;
      bit_idx  <= '0;
      cnt      <= CW'(BAUD_DIV - 1);
      shreg    <= data;
      uart_txd <= 1'b0;
    end else if (byte_done) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        cnt     <= CW'(BAUD_DIV - 1);
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd8) begin
          uart_txd <= 1'b1;
        end else begin
          uart_txd <= shreg[0];
          shreg    <= {1'b0, shreg[7:1]};
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_encode.sv
// Frame transmitter: wraps addr + payload as HEAD1 HEAD2 ADDR payload END and
// streams the bytes through the 8N1 serializer.
module uart_frame_encode
  import dds_uart_pkg::*;
#(
  parameter int         UART_BPS      = 115200,
  parameter int         CLK_FREQ      = 50000000,
  parameter logic [7:0] HEAD_FREAME_1 = HEAD1_DEF,
  parameter logic [7:0] HEAD_FREAME_2 = HEAD2_DEF,
  parameter logic [7:0] END_FREAME    = END_DEF,
  parameter int         PAYLOAD_BYTES = 7
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_frame_encode_if.slave  req,
  output logic                busy,
  output logic                frame_done,
  output logic                uart_txd
);
  localparam int BAUD_DIV  = baud_div(CLK_FREQ, UART_BPS);
  localparam int FRAME_LEN = PAYLOAD_BYTES + 4;
  localparam int IW        = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  frame_state_t               state, state_n;
  logic [IW-1:0]              idx, idx_n, sel;
  logic                       first, first_n;
  logic                       load, byte_done, ready_q;
  logic [7:0]                 addr_q, tx_byte;
  logic [8*PAYLOAD_BYTES-1:0] data_q, data_sh;

  assign req.req_ready = ready_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      first      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      first      <= first_n;
      ready_q    <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
      frame_done <= (state_n == ST_DONE);
      if (state == ST_IDLE && req.req_valid) begin
        addr_q <= req.req_addr;
        data_q <= req.req_data;
      end
    end
  end

  // On a byte_done the next byte is loaded in the same cycle (sel = idx+1),
  // so the next start bit follows the stop bit without an idle gap.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    first_n = first;
    load    = 1'b0;
    sel     = idx;
    case (state)
      ST_IDLE: begin
        if (req.req_valid) begin
          state_n = ST_SEND;
          idx_n   = '0;
          first_n = 1'b1;
        end
      end
      ST_SEND: begin
        if (first) begin
          load    = 1'b1;
          first_n = 1'b0;
        end else if (byte_done) begin
          if (idx == LAST_IDX) begin
            state_n = ST_DONE;
          end else begin
            idx_n = idx + 1'b1;
            sel   = idx + 1'b1;
            load  = 1'b1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign data_sh = data_q << (8 * (int'(sel) - 3));

  always_comb begin
    tx_byte = END_FREAME;
    if (sel == IW'(0))           tx_byte = HEAD_FREAME_1;
    else if (sel == IW'(1))      tx_byte = HEAD_FREAME_2;
    else if (sel == IW'(2))      tx_byte = addr_q;
    else if (sel != LAST_IDX)    tx_byte = data_sh[8*PAYLOAD_BYTES-1 -: 8];
  end

  uart_byte_ser #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (load),
    .data      (tx_byte),
    .uart_txd  (uart_txd),
    .byte_done (byte_done)
  );

endmodule
